ws_bus_initiator: RTL and testbench
===================================

# ws_bus_initiator

Drives WonderSwan cartridge bus cycles (memory and I/O, read and write) from a simple request/acknowledge command port, clocked by FastClk. It is the console side of the cartridge interface that the nileswan cartridge FPGA responds to. It lets the bench-top test fixture and the bring-up board exercise a cartridge (bank registers, SPI control, PSRAM/SRAM, boot ROM) without a real console. An optional SClk generator also provides the clock the cartridge's MBC unlock logic needs.

## Interface
- SETUP_CYCLES, 1: FastClk cycles with address/nSel/nIO valid before strobe; ≥1
- STROBE_CYCLES, 2: cycles nOE or nWE held low; ≥1
- HOLD_CYCLES, 1: cycles after strobe release with nSel, address and write data held; ≥1
- SCLK_DIV, 8: FastClk cycles per SClk half-period; ≥1; used only with WS_SCLK_GEN_EN
- FastClk  in  1  sole clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high
- Req  in  1  command valid; hold high until Ack
- ReqWrite  in  1  1 = write, 0 = read
- ReqIO  in  1  1 = I/O cycle, 0 = memory cycle
- ReqAddr  in  20  byte address; I/O uses [7:0]
- ReqData  in  16  write data; I/O uses [7:0]
- Ack  out  1  one-cycle pulse at cycle completion
- ReadData  out  16  read result, valid with Ack, held until next Ack
- Busy  out  1  high from command acceptance until Ack
- Addr  out  20  bus address
- nSel, nOE, nWE, nIO  out  1 each  bus strobes, active-low
- DataOut  out  16  bus write data
- DataOutEn  out  16  per-bit drive enable for the board tristate
- DataIn  in  16  bus read data
- SClk  out  1  cartridge serial clock

## Operation
- States: IDLE, SETUP, STROBE, HOLD. One down-counter, width $clog2(max param + 1), reloaded on each state entry.
- IDLE: if Req, latch command, Busy←1, go to SETUP. Req is ignored in every other state.
- SETUP: Addr = latched address; I/O cycles zero-extend [7:0] to 20 bits. nSel=0; nIO=~ReqIO. Writes drive DataOutEn: 16'hFFFF for memory, 16'h00FF for I/O. Stay SETUP_CYCLES.
- STROBE: nOE=0 for reads, nWE=0 for writes. Stay STROBE_CYCLES. On the last STROBE cycle, capture DataIn into ReadData; I/O reads zero [15:8].
- HOLD: strobes high; nSel, Addr and data drive unchanged, so the cartridge latches on the nWE rising edge with stable data. Stay HOLD_CYCLES.
- On the edge leaving HOLD: nSel=1, nIO=1, DataOutEn=0, Addr held, Ack=1 for one cycle, Busy=0, return to IDLE.
- Req dropped mid-cycle: the cycle completes and Ack still pulses.
- Never assert nOE and nWE together. Never drive DataOutEn during reads.

## Timing
- Reset values: nSel=nOE=nWE=nIO=1, Addr=0, DataOut=0, DataOutEn=0, Ack=0, Busy=0, ReadData=0, SClk=0, state IDLE.
- Reset mid-cycle: strobes deassert and the bus is released asynchronously; no Ack.
- All bus outputs are registered; no combinational path from Req to the bus.
- Req sampled high at edge 0: nSel falls after edge 0; strobe falls SETUP_CYCLES later; strobe rises STROBE_CYCLES later; nSel rises with Ack HOLD_CYCLES later.
- Latency from acceptance to Ack = SETUP+STROBE+HOLD cycles (4 at defaults).
- Back-to-back: Req still high in the Ack cycle starts the next cycle on the following edge. nSel is high for at least one cycle between cycles.

## Configuration
- WS_SCLK_GEN_EN defined: SClk toggles free-running every SCLK_DIV FastClk cycles after reset release, independent of bus cycles.
- WS_SCLK_GEN_EN undefined: SClk is tied to 0 and the divider is not built.

## Structure
- Shared package ws_bus_pkg: state enum; default timing constants; I/O address width (8); the nileswan register addresses used by benches (0xC0–0xC3, 0xCE, 0xD0–0xD5, 0xE0–0xE5).
- Sub-module ws_sclk_gen: parameterised divider; instantiated only under WS_SCLK_GEN_EN.

## Test plan
- Memory write 0x20000 ← 0xBEEF, defaults: nSel low 4 cycles, nWE low cycles 2–3 only, DataOut 0xBEEF with DataOutEn 0xFFFF through nWE rise, Ack in cycle 5.
- I/O read 0xE2 with DataIn 0xA503: Addr 0x000E2, nIO=0, nOE low 2 cycles, ReadData 0x0003, DataOutEn stays 0.
- I/O write 0xC2 ← 0x12 followed by a memory read at 0x20000, Req held through both: exactly one nSel-high cycle between cycles; DataOutEn 0x00FF during the write.
- Req pulsed for one cycle: full cycle and single Ack; a second Req pulse while Busy is ignored.
- Reset asserted in STROBE of a write: nWE, nSel, DataOutEn release with no clock edge; no Ack; IDLE afterwards.
- SCLK_DIV=3 with WS_SCLK_GEN_EN: SClk period 6 FastClk cycles; without the macro, SClk stays 0.

Source files
------------

// File: rtl/ws_bus_pkg.sv
// Shared types and constants for the WonderSwan cartridge bus initiator.
// Holds the state enum, the default timing values, the I/O address width and the nileswan register addresses.
package ws_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } ws_state_e;

  localparam int unsigned DEF_SETUP_CYCLES  = 1;
  localparam int unsigned DEF_STROBE_CYCLES = 2;
  localparam int unsigned DEF_HOLD_CYCLES   = 1;
  localparam int unsigned DEF_SCLK_DIV      = 8;

  localparam int unsigned IO_ADDR_W = 8;

  // Cartridge mapper registers, followed by the nileswan extensions.
  localparam logic [7:0] REG_BANK_ROM_LINEAR = 8'hC0;
  localparam logic [7:0] REG_BANK_RAM        = 8'hC1;
  localparam logic [7:0] REG_BANK_ROM0       = 8'hC2;
  localparam logic [7:0] REG_BANK_ROM1       = 8'hC3;
  localparam logic [7:0] REG_MEM_CTRL        = 8'hCE;
  localparam logic [7:0] REG_BANK_RAM_LO     = 8'hD0;
  localparam logic [7:0] REG_BANK_RAM_HI     = 8'hD1;
  localparam logic [7:0] REG_BANK_ROM0_LO    = 8'hD2;
  localparam logic [7:0] REG_BANK_ROM0_HI    = 8'hD3;
  localparam logic [7:0] REG_BANK_ROM1_LO    = 8'hD4;
  localparam logic [7:0] REG_BANK_ROM1_HI    = 8'hD5;
  localparam logic [7:0] NILE_SPI_CNT_LO     = 8'hE0;
  localparam logic [7:0] NILE_SPI_CNT_HI     = 8'hE1;
  localparam logic [7:0] NILE_POW_CNT        = 8'hE2;
  localparam logic [7:0] NILE_EMU_CNT        = 8'hE3;
  localparam logic [7:0] NILE_BANK_MASK_LO   = 8'hE4;
  localparam logic [7:0] NILE_BANK_MASK_HI   = 8'hE5;

endpackage

// File: rtl/ws_sclk_gen.sv
// Free-running SClk divider: the output toggles every DIV clock cycles, so the period is 2*DIV.
module ws_sclk_gen #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic sclk
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         sclk_q, sclk_d;

  always_comb begin
    cnt_d  = cnt_q + W'(1);
    sclk_d = sclk_q;
    if (cnt_q == W'(DIV - 1)) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/ws_bus_initiator.sv
// WonderSwan cartridge bus initiator: turns Req/Ack commands into registered SETUP/STROBE/HOLD bus cycles.
// Define WS_SCLK_GEN_EN to build the free-running SClk divider; otherwise SClk is tied low.
module ws_bus_initiator
  import ws_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned SCLK_DIV      = DEF_SCLK_DIV
) (
  input  logic        FastClk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic        ReqIO,
  input  logic [19:0] ReqAddr,
  input  logic [15:0] ReqData,
  output logic        Ack,
  output logic [15:0] ReadData,
  output logic        Busy,
  output logic [19:0] Addr,
  output logic        nSel,
  output logic        nOE,
  output logic        nWE,
  output logic        nIO,
  output logic [15:0] DataOut,
  output logic [15:0] DataOutEn,
  input  logic [15:0] DataIn,
  output logic        SClk
);

  localparam int unsigned MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  if (SETUP_CYCLES == 0 || STROBE_CYCLES == 0 || HOLD_CYCLES == 0 || SCLK_DIV == 0) begin : g_param_err
    $error("ws_bus_initiator: all timing parameters must be at least 1");
  end

  ws_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic        is_io_q, is_io_d;
  logic [19:0] addr_q, addr_d;
  logic        nsel_q, nsel_d, noe_q, noe_d, nwe_q, nwe_d, nio_q, nio_d;
  logic [15:0] data_out_q, data_out_d;
  logic [15:0] data_oe_q, data_oe_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [15:0] rd_stage_q, rd_stage_d;
  logic [15:0] read_data_q, read_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    is_write_d  = is_write_q;
    is_io_d     = is_io_q;
    addr_d      = addr_q;
    nsel_d      = nsel_q;
    noe_d       = noe_q;
    nwe_d       = nwe_q;
    nio_d       = nio_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    rd_stage_d  = rd_stage_q;
    read_data_d = read_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Req) begin
          state_d    = ST_SETUP;
          cnt_d      = CW'(SETUP_CYCLES - 1);
          is_write_d = ReqWrite;
          is_io_d    = ReqIO;
          addr_d     = ReqIO ? {{(20-IO_ADDR_W){1'b0}}, ReqAddr[IO_ADDR_W-1:0]} : ReqAddr;
          nsel_d     = 1'b0;
          nio_d      = ~ReqIO;
          busy_d     = 1'b1;
          if (ReqWrite) begin
            data_out_d = ReqIO ? {8'h00, ReqData[7:0]} : ReqData;
            data_oe_d  = ReqIO ? 16'h00FF : 16'hFFFF;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(STROBE_CYCLES - 1);
          noe_d   = is_write_q;
          nwe_d   = ~is_write_q;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d    = ST_HOLD;
          cnt_d      = CW'(HOLD_CYCLES - 1);
          noe_d      = 1'b1;
          nwe_d      = 1'b1;
          rd_stage_d = is_io_q ? {8'h00, DataIn[7:0]} : DataIn;
        end
      end
      ST_HOLD: begin
        // Data and nSel stay driven through HOLD so the nWE rising edge sees stable data.
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          nsel_d    = 1'b1;
          nio_d     = 1'b1;
          data_oe_d = '0;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          if (!is_write_q) read_data_d = rd_stage_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      is_io_q     <= 1'b0;
      addr_q      <= '0;
      nsel_q      <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      nio_q       <= 1'b1;
      data_out_q  <= '0;
      data_oe_q   <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_stage_q  <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      is_io_q     <= is_io_d;
      addr_q      <= addr_d;
      nsel_q      <= nsel_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      nio_q       <= nio_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      rd_stage_q  <= rd_stage_d;
      read_data_q <= read_data_d;
    end
  end

  assign Ack       = ack_q;
  assign ReadData  = read_data_q;
  assign Busy      = busy_q;
  assign Addr      = addr_q;
  assign nSel      = nsel_q;
  assign nOE       = noe_q;
  assign nWE       = nwe_q;
  assign nIO       = nio_q;
  assign DataOut   = data_out_q;
  assign DataOutEn = data_oe_q;

`ifdef WS_SCLK_GEN_EN
  ws_sclk_gen #(.DIV(SCLK_DIV)) u_sclk_gen (
    .clk  (FastClk),
    .rst  (Reset),
    .sclk (SClk)
  );
`else
  assign SClk = 1'b0;
`endif

endmodule

// File: tb/tb_ws_bus_initiator.sv
// Directed bench for ws_bus_initiator: table of single bus cycles plus hand-written corner-case sequences.
module tb_ws_bus_initiator;

  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;
  localparam int TOT    = SETUP + STROBE + HOLD;
  localparam int SDIV   = 3;

  logic        FastClk = 1'b0;
  logic        Reset   = 1'b1;
  logic        Req = 1'b0, ReqWrite = 1'b0, ReqIO = 1'b0;
  logic [19:0] ReqAddr = '0;
  logic [15:0] ReqData = '0;
  logic [15:0] DataIn  = '0;
  logic        Ack, Busy, nSel, nOE, nWE, nIO, SClk;
  logic [15:0] ReadData, DataOut, DataOutEn;
  logic [19:0] Addr;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  ws_bus_initiator #(
    .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD), .SCLK_DIV(SDIV)
  ) dut (
    .FastClk(FastClk), .Reset(Reset), .Req(Req), .ReqWrite(ReqWrite), .ReqIO(ReqIO),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .Ack(Ack), .ReadData(ReadData), .Busy(Busy),
    .Addr(Addr), .nSel(nSel), .nOE(nOE), .nWE(nWE), .nIO(nIO), .DataOut(DataOut),
    .DataOutEn(DataOutEn), .DataIn(DataIn), .SClk(SClk)
  );

  always #5 FastClk = ~FastClk;

  always @(negedge FastClk) if (!nOE && !nWE) overlap++;

  typedef struct {
    logic        wr;
    logic        io;
    logic [19:0] addr;
    logic [15:0] data;
    logic [15:0] din;
    logic [19:0] exp_addr;
    logic        exp_nio;
    logic [15:0] exp_oe;
    logic [15:0] exp_dout;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int ack_k = 0, sel_bad = 0, str_bad = 0, oth_bad = 0, oe_bad = 0;
    int addr_bad = 0, nio_bad = 0, dout_bad = 0;
    logic busy1 = 1'b0, busy_ack = 1'b1;
    logic [15:0] rd = '0;
    @(negedge FastClk);
    Req = 1'b1; ReqWrite = v.wr; ReqIO = v.io; ReqAddr = v.addr; ReqData = v.data; DataIn = v.din;
    for (int k = 1; k <= 12 && ack_k == 0; k++) begin
      bit exp_sel, exp_str;
      @(negedge FastClk);
      exp_sel = (k <= TOT);
      exp_str = (k > SETUP) && (k <= SETUP + STROBE);
      if (k == 1) busy1 = Busy;
      if (Ack) begin ack_k = k; Req = 1'b0; rd = ReadData; busy_ack = Busy; end
      if (nSel !== !exp_sel) sel_bad++;
      if ((v.wr ? nWE : nOE) !== !exp_str) str_bad++;
      if ((v.wr ? nOE : nWE) !== 1'b1) oth_bad++;
      if (DataOutEn !== (exp_sel ? v.exp_oe : 16'h0000)) oe_bad++;
      if (exp_sel) begin
        if (Addr !== v.exp_addr) addr_bad++;
        if (nIO !== v.exp_nio) nio_bad++;
        if (v.wr && DataOut !== v.exp_dout) dout_bad++;
      end else if (nIO !== 1'b1) nio_bad++;
    end
    Req = 1'b0;
    check({tag, "/ack_cycle"}, ack_k, TOT + 1);
    check({tag, "/nsel_pattern"}, sel_bad, 0);
    check({tag, "/strobe_pattern"}, str_bad, 0);
    check({tag, "/other_strobe"}, oth_bad, 0);
    check({tag, "/data_oe"}, oe_bad, 0);
    check({tag, "/addr"}, addr_bad, 0);
    check({tag, "/nio"}, nio_bad, 0);
    if (v.wr) check({tag, "/data_out"}, dout_bad, 0);
    check({tag, "/read_data"}, rd, v.exp_rdata);
    check({tag, "/busy"}, {busy1, busy_ack}, 2'b10);
  endtask

  initial begin
    // wr io addr data din | exp_addr nio oe dout rdata
    vecs[0] = '{1'b1, 1'b0, 20'h20000, 16'hBEEF, 16'h0000, 20'h20000, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 20'h000E2, 16'h0000, 16'hA503, 20'h000E2, 1'b0, 16'h0000, 16'h0000, 16'h0003};
    vecs[2] = '{1'b0, 1'b0, 20'h3ABCD, 16'h0000, 16'h1234, 20'h3ABCD, 1'b1, 16'h0000, 16'h0000, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 20'hFFFC2, 16'h0012, 16'h9999, 20'h000C2, 1'b0, 16'h00FF, 16'h0012, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 20'hFFFFF, 16'h0000, 16'hFFFF, 20'hFFFFF, 1'b1, 16'h0000, 16'h0000, 16'hFFFF};

    // Reset values while reset is held.
    @(negedge FastClk);
    @(negedge FastClk);
    check("rst/strobes", {nSel, nOE, nWE, nIO}, 4'hF);
    check("rst/addr", Addr, 20'h0);
    check("rst/data_out", DataOut, 16'h0);
    check("rst/data_oe", DataOutEn, 16'h0);
    check("rst/ack_busy", {Ack, Busy}, 2'b00);
    check("rst/read_data", ReadData, 16'h0);
    check("rst/sclk", SClk, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: I/O write then memory read with Req held throughout.
    begin
      int phase = 0, gap = 0, oe_bad = 0, rd_bad = 0;
      logic [15:0] rd = '0;
      @(negedge FastClk);
      Req = 1'b1; ReqWrite = 1'b1; ReqIO = 1'b1; ReqAddr = 20'h000C2; ReqData = 16'h0012; DataIn = 16'h5A5A;
      for (int k = 0; k < 30 && phase < 3; k++) begin
        @(negedge FastClk);
        case (phase)
          0: begin
            if (!nSel && (DataOutEn !== 16'h00FF || DataOut !== 16'h0012)) oe_bad++;
            if (Ack) begin
              phase = 1; gap = nSel ? 1 : 0;
              ReqWrite = 1'b0; ReqIO = 1'b0; ReqAddr = 20'h20000;
            end
          end
          1: begin
            if (nSel) gap++;
            else begin
              phase = 2;
              if (Addr !== 20'h20000 || nIO !== 1'b1 || DataOutEn !== 16'h0) rd_bad++;
            end
          end
          default: begin
            if (DataOutEn !== 16'h0) rd_bad++;
            if (Ack) begin phase = 3; Req = 1'b0; rd = ReadData; end
          end
        endcase
      end
      Req = 1'b0;
      check("b2b/done", phase, 3);
      check("b2b/nsel_gap", gap, 1);
      check("b2b/io_write_drive", oe_bad, 0);
      check("b2b/mem_read_bus", rd_bad, 0);
      check("b2b/read_data", rd, 16'h5A5A);
    end

    // One-cycle Req pulse, then a second pulse while Busy that must be ignored.
    begin
      int acks = 0, ack_k = 0, nwe_low = 0;
      logic busy_mid = 1'b0;
      @(negedge FastClk);
      Req = 1'b1; ReqWrite = 1'b0; ReqIO = 1'b0; ReqAddr = 20'h00010; DataIn = 16'h7777;
      for (int k = 1; k <= 14; k++) begin
        @(negedge FastClk);
        if (k == 1) Req = 1'b0;
        if (k == 2) begin busy_mid = Busy; Req = 1'b1; ReqWrite = 1'b1; ReqAddr = 20'h00020; end
        if (k == 3) Req = 1'b0;
        if (Ack) begin acks++; ack_k = k; end
        if (!nWE) nwe_low++;
      end
      check("pulse/busy_mid", busy_mid, 1'b1);
      check("pulse/ack_count", acks, 1);
      check("pulse/ack_cycle", ack_k, TOT + 1);
      check("pulse/no_write", nwe_low, 0);
      check("pulse/read_data", ReadData, 16'h7777);
    end

    // Reset asserted during the write strobe releases the bus without a clock edge.
    begin
      bit seen = 1'b0;
      int acks = 0;
      @(negedge FastClk);
      Req = 1'b1; ReqWrite = 1'b1; ReqIO = 1'b0; ReqAddr = 20'h12345; ReqData = 16'hCAFE;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge FastClk);
        if (!nWE) seen = 1'b1;
      end
      check("rstmid/strobe_seen", seen, 1'b1);
      #2 Reset = 1'b1;
      #1;
      check("rstmid/released", {nWE, nSel, nOE, nIO}, 4'hF);
      check("rstmid/data_oe", DataOutEn, 16'h0);
      check("rstmid/busy_ack", {Busy, Ack}, 2'b00);
      Req = 1'b0;
      @(negedge FastClk);
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge FastClk);
        if (Ack || !nSel) acks++;
      end
      check("rstmid/no_ack", acks, 0);
      run_txn('{1'b0, 1'b1, 20'h000CE, 16'h0000, 16'hFF5C, 20'h000CE, 1'b0, 16'h0000, 16'h0000, 16'h005C},
              "post_rst");
    end

    // SClk behaviour depends on the build.
    begin
`ifdef WS_SCLK_GEN_EN
      int last = -1, edges = 0, bad = 0;
      logic prev;
      @(negedge FastClk);
      prev = SClk;
      for (int k = 0; k < 30; k++) begin
        @(negedge FastClk);
        if (SClk !== prev) begin
          if (last >= 0 && (k - last) != SDIV) bad++;
          last = k; edges++; prev = SClk;
        end
      end
      check("sclk/edges", (edges >= 8) ? 1 : 0, 1);
      check("sclk/half_period", bad, 0);
`else
      int highs = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge FastClk);
        if (SClk !== 1'b0) highs++;
      end
      check("sclk/tied_low", highs, 0);
`endif
    end

    check("never_oe_and_we", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
